// File: rtl/rnorm_pkg.sv
// Shared constants, state encoding and quotient saturation for the row-normalisation stage.
// Fixed point is Q(W-FRAC).FRAC; RW is the widened radicand/dividend width.
package rnorm_pkg;
    localparam int W      = 26;
    localparam int FRAC   = 20;
    localparam int RW     = W + FRAC;
    localparam int SQ_CYC = RW / 2;
    localparam int DV_CYC = RW;
    localparam int CW     = 6;

    localparam logic [W-1:0] QMAX = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, SQRT, DIV, WB, DONE} state_e;
    typedef logic signed [W-1:0] elem_t;

    function automatic logic [W-1:0] sat_mag(input logic [RW-1:0] q);
        return (q > {{(RW-W){1'b0}}, QMAX}) ? QMAX : q[W-1:0];
    endfunction
endpackage

// File: rtl/row_norm_div_if.sv
// Matrix/sum inputs and normalised outputs of row_norm_div.
// Element i[r][c] corresponds to i<r+1><c+1>; same indexing for o and sum.
interface row_norm_div_if;
    import rnorm_pkg::*;

    logic       en_rnorm;
    elem_t      i   [4][4];
    elem_t      sum [4];
    elem_t      o   [4][4];
    logic       busy;
    logic       done;
    logic [3:0] zero_row;

    modport master (output en_rnorm, i, sum, input o, busy, done, zero_row);
    modport slave  (input en_rnorm, i, sum, output o, busy, done, zero_row);
endinterface

// File: rtl/seq_udiv.sv
// Unsigned restoring divider: one quotient bit per cycle, DV_CYC steps.
// The first step runs on the start edge using the input operands directly.
module seq_udiv
    import rnorm_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [RW-1:0] dividend_i,
    input  logic [W-1:0]  divisor_i,
    output logic          busy_o,
    output logic [RW-1:0] quot_o
);
    logic [RW-1:0] dvd_q, dvd_d, dvd_cur;
    logic [W-1:0]  rem_q, rem_d, rem_cur;
    logic [W-1:0]  dvs_q, dvs_cur;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]    rem_t;
    logic          step;

    assign step   = start_i || (cnt_q != '0);
    assign busy_o = (cnt_q != '0);
    assign quot_o = dvd_q;

    // Dividend register shifts left while quotient bits enter at the bottom.
    always_comb begin
        dvd_cur = start_i ? dividend_i : dvd_q;
        rem_cur = start_i ? '0 : rem_q;
        dvs_cur = start_i ? divisor_i : dvs_q;
        rem_t   = {rem_cur, dvd_cur[RW-1]};
        if (rem_t >= {1'b0, dvs_cur}) begin
            rem_d = W'(rem_t - {1'b0, dvs_cur});
            dvd_d = {dvd_cur[RW-2:0], 1'b1};
        end else begin
            rem_d = rem_t[W-1:0];
            dvd_d = {dvd_cur[RW-2:0], 1'b0};
        end
        if (start_i) begin
            cnt_d = CW'(DV_CYC - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            dvd_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (step) begin
                dvd_q <= dvd_d;
                rem_q <= rem_d;
                dvs_q <= dvs_cur;
            end
        end
    end
endmodule

// File: rtl/row_norm_div.sv
// Row normaliser: per row, bit-serial sqrt of the sum of squares, then four
// parallel dividers scale the row elements by 1/norm. Fixed latency per matrix.
module row_norm_div
    import rnorm_pkg::*;
(
    input  logic          clk_rnorm,
    input  logic          rst_rnorm,
    row_norm_div_if.slave bus
);
    localparam int SW = W + 2;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    row_q, row_d;

    elem_t         mat_q [4][4];
    elem_t         sum_q [4];
    elem_t         o_q   [4][4];
    logic [3:0]    zr_q;

    logic [RW-1:0] rad_q, rad_d, rad_cur;
    logic [W-1:0]  rem_q, rem_d, rem_cur;
    logic [W-1:0]  root_q, root_d, root_cur;
    logic [SW-1:0] rem_t, trial;

    logic          accept, div_start, row_pos, wb_en;
    logic [3:0]    div_busy;
    logic [RW-1:0] quot   [4];
    logic [W-1:0]  mag    [4];
    elem_t         wb_val [4];
    elem_t         cur_sum;

    assign accept    = (state_q == IDLE) && bus.en_rnorm;
    assign div_start = (state_q == DIV) && (cnt_q == '0);
    assign wb_en     = (state_q == WB) && !(|div_busy);
    assign cur_sum   = sum_q[row_q];
    assign row_pos   = !cur_sum[W-1] && (cur_sum != '0);

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.zero_row = zr_q;
    assign bus.o        = o_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (bus.en_rnorm) begin
                    state_d = SQRT;
                    cnt_d   = '0;
                    row_d   = '0;
                end
            end
            SQRT: begin
                if (cnt_q == CW'(SQ_CYC - 1)) begin
                    state_d = DIV;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DIV: begin
                if (cnt_q == CW'(DV_CYC - 1)) begin
                    state_d = WB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WB: begin
                row_d   = row_q + 1'b1;
                state_d = (row_q == 2'd3) ? DONE : SQRT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_rnorm) begin
        if (rst_rnorm) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
        end
    end

    always_ff @(posedge clk_rnorm) begin
        if (accept) begin
            mat_q <= bus.i;
            sum_q <= bus.sum;
        end
    end

    // Restoring sqrt, two radicand bits per step; first step loads the row's sum.
    always_comb begin
        rad_cur  = rad_q;
        rem_cur  = rem_q;
        root_cur = root_q;
        if (cnt_q == '0) begin
            rad_cur  = {cur_sum, {FRAC{1'b0}}};
            rem_cur  = '0;
            root_cur = '0;
        end
        rem_t = {rem_cur, rad_cur[RW-1:RW-2]};
        trial = {root_cur, 2'b01};
        rad_d = {rad_cur[RW-3:0], 2'b00};
        if (rem_t >= trial) begin
            rem_d  = W'(rem_t - trial);
            root_d = {root_cur[W-2:0], 1'b1};
        end else begin
            rem_d  = rem_t[W-1:0];
            root_d = {root_cur[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_rnorm) begin
        if (rst_rnorm) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
        end else if (state_q == SQRT) begin
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mag[c]    = mat_q[row_q][c][W-1] ? W'(-mat_q[row_q][c]) : mat_q[row_q][c];
            wb_val[c] = '0;
            if (row_pos) begin
                wb_val[c] = mat_q[row_q][c][W-1] ? -elem_t'(sat_mag(quot[c]))
                                                 :  elem_t'(sat_mag(quot[c]));
            end
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_div
        seq_udiv u_div (
            .clk_i      (clk_rnorm),
            .rst_i      (rst_rnorm),
            .start_i    (div_start),
            .dividend_i ({mag[c], {FRAC{1'b0}}}),
            .divisor_i  (root_q),
            .busy_o     (div_busy[c]),
            .quot_o     (quot[c])
        );
    end

    // Non-positive sums (including wrapped overflow) zero the whole row.
    always_ff @(posedge clk_rnorm) begin
        if (rst_rnorm) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    o_q[r][c] <= '0;
                end
            end
            zr_q <= '0;
        end else if (accept) begin
            zr_q <= '0;
        end else if (wb_en) begin
            for (int c = 0; c < 4; c++) begin
                o_q[row_q][c] <= wb_val[c];
            end
            zr_q[row_q] <= !row_pos;
        end
    end
endmodule

// File: tb/tb_row_norm_div.sv
// Scoreboard bench for row_norm_div: expected matrices from an integer model are
// queued at accept and checked, with latency, when done pulses.
module tb_row_norm_div;
    import rnorm_pkg::*;

    localparam longint ONE   = longint'(1) << FRAC;
    localparam longint QMAXL = 64'd33554431;
    localparam longint LAT   = 280;

    typedef struct packed {
        logic [15:0][63:0] o;
        logic [3:0]        zr;
        logic [63:0]       acc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;
    int     total = 0;
    int     bad = 0;
    exp_t   expQ [$];
    longint mat  [4][4];
    longint sums [4];

    row_norm_div_if bus ();

    row_norm_div dut (
        .clk_rnorm (clk),
        .rst_rnorm (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, expv, cyc);
        end
    endtask

    function automatic longint isqrt(input longint n);
        longint lo, hi, mid;
        lo = 0;
        hi = 64'd16777216;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= n) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    function automatic exp_t buildExp(input longint acc);
        exp_t   e;
        longint root, q, m;
        e = '0;
        e.acc = acc;
        for (int r = 0; r < 4; r++) begin
            if (sums[r] <= 0) begin
                e.zr[r] = 1'b1;
            end else begin
                root = isqrt(sums[r] * ONE);
                for (int c = 0; c < 4; c++) begin
                    m = (mat[r][c] < 0) ? -mat[r][c] : mat[r][c];
                    q = (m * ONE) / root;
                    if (q > QMAXL) q = QMAXL;
                    e.o[r*4+c] = (mat[r][c] < 0) ? -q : q;
                end
            end
        end
        return e;
    endfunction

    task automatic setIdentity();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) mat[r][c] = (r == c) ? ONE : 0;
            sums[r] = ONE;
        end
    endtask

    task automatic driveInputs();
        longint tmp;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                tmp = mat[r][c];
                bus.i[r][c] = tmp[W-1:0];
            end
            tmp = sums[r];
            bus.sum[r] = tmp[W-1:0];
        end
    endtask

    task automatic waitIdle(input int limit);
        int n = 0;
        while ((expQ.size() != 0 || bus.busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) checkOutput("wait_idle", longint'(bus.busy), 0);
    endtask

    task automatic applyStimulus(input bit hold, output longint acc);
        waitIdle(400);
        driveInputs();
        bus.en_rnorm = 1'b1;
        acc = cyc + 1;
        expQ.push_back(buildExp(acc));
        @(negedge clk);
        checkOutput("busy_accept", longint'(bus.busy), 1);
        if (!hold) bus.en_rnorm = 1'b0;
    endtask

    // Scoreboard pop on every done pulse.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_done", longint'(bus.done), 0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("latency", cyc - longint'(e.acc), LAT);
                checkOutput("busy_at_done", longint'(bus.busy), 1);
                checkOutput("zero_row", longint'(bus.zero_row), longint'(e.zr));
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        checkOutput($sformatf("o%0d%0d", r + 1, c + 1),
                                    longint'(bus.o[r][c]), longint'($signed(e.o[r*4+c])));
                    end
                end
            end
        end
    end

    initial begin
        longint acc, s;
        int     guard;
        bus.en_rnorm = 1'b0;
        setIdentity();
        driveInputs();
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", longint'(bus.busy), 0);
        checkOutput("rst_done", longint'(bus.done), 0);
        checkOutput("rst_zero_row", longint'(bus.zero_row), 0);
        checkOutput("rst_o11", longint'(bus.o[0][0]), 0);
        checkOutput("rst_o44", longint'(bus.o[3][3]), 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] identity matrix");
        setIdentity();
        mat[0][1] = -3 * ONE / 4;
        mat[2][3] = ONE / 2;
        applyStimulus(1'b0, acc);
        waitIdle(400);

        $display("[TB] 3-4-5 row, negative row, zero and negative sums, ignored en");
        setIdentity();
        mat[0][0] = 3 * ONE; mat[0][1] = 4 * ONE; sums[0] = 25 * ONE;
        mat[1][0] = -ONE;    mat[1][1] = 0;       sums[1] = ONE;
        mat[2][0] = ONE;     mat[2][2] = 2 * ONE; sums[2] = 0;
        mat[3][1] = -ONE;    sums[3] = -5;
        applyStimulus(1'b0, acc);
        repeat (30) @(negedge clk);
        bus.i[0][0] = 26'sd12345;
        bus.sum[0] = 26'sd1;
        bus.en_rnorm = 1'b1;
        @(negedge clk);
        bus.en_rnorm = 1'b0;
        checkOutput("busy_ignore", longint'(bus.busy), 1);
        waitIdle(400);

        $display("[TB] tiny norm saturation");
        setIdentity();
        mat[0][0] = 64'd16777216; mat[0][1] = -64'd16777216;
        mat[0][2] = 5;            mat[0][3] = 0;
        sums[0] = 1;
        applyStimulus(1'b0, acc);
        waitIdle(400);

        $display("[TB] random rows");
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 4; r++) begin
                s = 0;
                for (int c = 0; c < 4; c++) begin
                    mat[r][c] = longint'($urandom_range(0, 4194303)) - 2097152;
                    s += (mat[r][c] * mat[r][c]) >>> FRAC;
                end
                sums[r] = s;
            end
            applyStimulus(1'b0, acc);
            waitIdle(400);
        end

        $display("[TB] reset mid-operation");
        setIdentity();
        applyStimulus(1'b0, acc);
        guard = 0;
        while (cyc < acc + 99 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        rst = 1'b1;
        expQ.delete();
        @(negedge clk);
        checkOutput("midrst_busy", longint'(bus.busy), 0);
        checkOutput("midrst_done", longint'(bus.done), 0);
        checkOutput("midrst_zero_row", longint'(bus.zero_row), 0);
        checkOutput("midrst_o11", longint'(bus.o[0][0]), 0);
        checkOutput("midrst_o12", longint'(bus.o[0][1]), 0);
        checkOutput("midrst_o22", longint'(bus.o[1][1]), 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] back-to-back with en held");
        setIdentity();
        mat[1][2] = -ONE / 3;
        applyStimulus(1'b1, acc);
        guard = 0;
        while (cyc < acc + 281 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("b2b_gap_busy", longint'(bus.busy), 0);
        expQ.push_back(buildExp(acc + 282));
        @(negedge clk);
        checkOutput("b2b_reaccept_busy", longint'(bus.busy), 1);
        bus.en_rnorm = 1'b0;
        waitIdle(400);
        repeat (5) @(negedge clk);
        checkOutput("queue_empty", longint'(expQ.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
